// File: rtl/mema_load_sched.sv
// A-operand buffer sequencer: loads DIM rows over valid/ready, then streams
// the skewed FIFO bank for STREAM_N enabled cycles and pulses done.
module mema_load_sched #(
    parameter int unsigned BITS_AB  = 8,
    parameter int unsigned DIM      = 8,
    parameter int unsigned STREAM_N = 3*DIM-1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      stall,
    input  logic                      row_valid,
    input  logic signed [BITS_AB-1:0] row_data [DIM-1:0],
    output logic                      row_ready,
    output logic signed [BITS_AB-1:0] Ain [DIM-1:0],
    output logic [$clog2(DIM)-1:0]    Arow,
    output logic                      WrEn,
    output logic                      en,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned AW = $clog2(DIM);
    localparam int unsigned SW = $clog2(STREAM_N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   row_cnt;
    logic [SW-1:0]   strm_cnt;

    // Row data goes straight to the buffer; only the row select is sequenced.
    assign Ain = row_data;

    // Handshake and enables are gated by abort so a cancel never commits a write or shift.
    always_comb begin
        row_ready = (state == LOAD) && !abort;
        WrEn      = row_valid && row_ready;
        en        = (state == STREAM) && !stall && !abort;
        busy      = (state == LOAD) || (state == STREAM);
        done      = (state == DONE);
        Arow      = row_cnt;
    end

    // Job sequencer: counts accepted rows, then enabled stream cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row_cnt  <= '0;
            strm_cnt <= '0;
        end else if (abort) begin
            state    <= IDLE;
            row_cnt  <= '0;
            strm_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        row_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (WrEn) begin
                        if (row_cnt == AW'(DIM-1)) begin
                            state    <= STREAM;
                            row_cnt  <= '0;
                            strm_cnt <= '0;
                        end else begin
                            row_cnt <= row_cnt + AW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (!stall) begin
                        if (strm_cnt == SW'(STREAM_N-1)) begin
                            state    <= DONE;
                            strm_cnt <= '0;
                        end else begin
                            strm_cnt <= strm_cnt + SW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mema_load_sched.sv
// Directed bench for mema_load_sched (DIM=8, BITS_AB=8, STREAM_N=23).
module tb_mema_load_sched;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              stall;
    logic              row_valid;
    logic signed [7:0] row_data [7:0];
    logic              row_ready;
    logic signed [7:0] Ain [7:0];
    logic [2:0]        Arow;
    logic              WrEn;
    logic              en;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    mema_load_sched #(.BITS_AB(8), .DIM(8), .STREAM_N(23)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
        .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
        .Ain(Ain), .Arow(Arow), .WrEn(WrEn), .en(en), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row k carries elements k*8+j in lane j.
    task automatic set_row(input int k);
        for (int j = 0; j < 8; j++) row_data[j] = 8'(k*8 + j);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0; abort = 1'b0; stall = 1'b0; row_valid = 1'b0;
        set_row(0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; row_valid = 1'b1; abort = 1'b0; stall = 1'b0;
        set_row(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({row_ready, WrEn, en, busy, done} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got %b exp 00000", {row_ready, WrEn, en, busy, done});
        end
        checks++; if (Arow !== 3'd0) begin
            errors++; $display("FAIL reset_arow got %0d exp 0", Arow);
        end
        next_cycle();
        start = 1'b0; row_valid = 1'b0; rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if ({busy, row_ready, WrEn} !== 3'b0) begin
                errors++; $display("FAIL reset_idle c=%0d got %b exp 000", c, {busy, row_ready, WrEn});
            end
            next_cycle();
        end
    endtask

    task automatic test_nominal();
        int en_cnt = 0;
        logic exp_wr, exp_en, exp_busy, exp_done;
        logic signed [7:0] e0, e7;
        clear_inputs();
        for (int c = 0; c < 35; c++) begin
            start = (c == 0); row_valid = 1'b1; set_row(c - 1);
            @(negedge clk);
            exp_wr = (c >= 1 && c <= 8);
            exp_en = (c >= 9 && c <= 31);
            exp_busy = (c >= 1 && c <= 31);
            exp_done = (c == 32);
            checks++; if (WrEn !== exp_wr) begin
                errors++; $display("FAIL nominal_wren c=%0d got %b exp %b", c, WrEn, exp_wr);
            end
            if (exp_wr) begin
                e0 = 8'((c-1)*8); e7 = 8'((c-1)*8 + 7);
                checks++; if (Arow !== 3'(c-1)) begin
                    errors++; $display("FAIL nominal_arow c=%0d got %0d exp %0d", c, Arow, c-1);
                end
                checks++; if (Ain[0] !== e0 || Ain[7] !== e7) begin
                    errors++; $display("FAIL nominal_ain c=%0d got %0d/%0d exp %0d/%0d", c, Ain[0], Ain[7], e0, e7);
                end
            end
            checks++; if (en !== exp_en) begin
                errors++; $display("FAIL nominal_en c=%0d got %b exp %b", c, en, exp_en);
            end
            checks++; if (busy !== exp_busy || done !== exp_done) begin
                errors++; $display("FAIL nominal_busy_done c=%0d got %b%b exp %b%b", c, busy, done, exp_busy, exp_done);
            end
            if (en) en_cnt++;
            next_cycle();
        end
        checks++; if (en_cnt != 23) begin
            errors++; $display("FAIL nominal_en_total got %0d exp 23", en_cnt);
        end
    endtask

    task automatic test_gapped();
        int wr_cnt = 0;
        logic exp_wr, exp_en, exp_done;
        logic signed [7:0] e3;
        clear_inputs();
        for (int c = 0; c < 42; c++) begin
            start = (c == 0);
            row_valid = (c % 2 == 1);
            if (c % 2 == 1) set_row((c-1)/2); else set_row(11);
            @(negedge clk);
            exp_wr = (c % 2 == 1) && (c <= 15);
            exp_en = (c >= 16 && c <= 38);
            exp_done = (c == 39);
            checks++; if (WrEn !== exp_wr) begin
                errors++; $display("FAIL gapped_wren c=%0d got %b exp %b", c, WrEn, exp_wr);
            end
            if (exp_wr) begin
                e3 = 8'(((c-1)/2)*8 + 3);
                checks++; if (Arow !== 3'((c-1)/2) || Ain[3] !== e3) begin
                    errors++; $display("FAIL gapped_arow_ain c=%0d got %0d/%0d exp %0d/%0d", c, Arow, Ain[3], (c-1)/2, e3);
                end
            end
            if (c == 16) begin
                checks++; if (row_ready !== 1'b0) begin
                    errors++; $display("FAIL gapped_ready_drop got %b exp 0", row_ready);
                end
            end
            checks++; if (en !== exp_en || done !== exp_done) begin
                errors++; $display("FAIL gapped_en_done c=%0d got %b%b exp %b%b", c, en, done, exp_en, exp_done);
            end
            if (WrEn) wr_cnt++;
            next_cycle();
        end
        checks++; if (wr_cnt != 8) begin
            errors++; $display("FAIL gapped_write_total got %0d exp 8", wr_cnt);
        end
    endtask

    task automatic test_stall();
        int en_cnt = 0;
        logic exp_en, exp_done;
        clear_inputs();
        for (int c = 0; c < 40; c++) begin
            start = (c == 0); row_valid = 1'b1; set_row(c - 1);
            stall = (c >= 15 && c <= 19);
            @(negedge clk);
            exp_en = (c >= 9 && c <= 36) && !(c >= 15 && c <= 19);
            exp_done = (c == 37);
            checks++; if (en !== exp_en) begin
                errors++; $display("FAIL stall_en c=%0d got %b exp %b", c, en, exp_en);
            end
            checks++; if (done !== exp_done) begin
                errors++; $display("FAIL stall_done c=%0d got %b exp %b", c, done, exp_done);
            end
            if (en) en_cnt++;
            next_cycle();
        end
        checks++; if (en_cnt != 23) begin
            errors++; $display("FAIL stall_en_total got %0d exp 23", en_cnt);
        end
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        clear_inputs();
        for (int c = 0; c < 46; c++) begin
            start = (c == 0) || (c == 6);
            row_valid = 1'b1;
            abort = (c == 4) || (c == 20);
            stall = (c == 20);
            if (c < 6) set_row(c - 1); else set_row(c - 7);
            @(negedge clk);
            if (c == 3) begin
                checks++; if (WrEn !== 1'b1 || Arow !== 3'd2) begin
                    errors++; $display("FAIL abort_pre got %b/%0d exp 1/2", WrEn, Arow);
                end
            end
            if (c == 4) begin
                checks++; if (WrEn !== 1'b0 || row_ready !== 1'b0) begin
                    errors++; $display("FAIL abort_load_cycle got %b%b exp 00", WrEn, row_ready);
                end
            end
            if (c == 5 || c == 21) begin
                checks++; if (busy !== 1'b0 || row_ready !== 1'b0 || en !== 1'b0) begin
                    errors++; $display("FAIL abort_idle c=%0d got %b%b%b exp 000", c, busy, row_ready, en);
                end
            end
            if (c == 7) begin
                checks++; if (WrEn !== 1'b1 || Arow !== 3'd0) begin
                    errors++; $display("FAIL abort_restart got %b/%0d exp 1/0", WrEn, Arow);
                end
            end
            if (c == 14) begin
                checks++; if (WrEn !== 1'b1 || Arow !== 3'd7) begin
                    errors++; $display("FAIL abort_restart_last got %b/%0d exp 1/7", WrEn, Arow);
                end
            end
            if (c == 15) begin
                checks++; if (en !== 1'b1) begin
                    errors++; $display("FAIL abort_stream_start got %b exp 1", en);
                end
            end
            if (c == 20) begin
                checks++; if (en !== 1'b0) begin
                    errors++; $display("FAIL abort_stream_cycle got %b exp 0", en);
                end
            end
            if (done) done_cnt++;
            next_cycle();
        end
        checks++; if (done_cnt != 0) begin
            errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt);
        end
    endtask

    task automatic test_ignored_start_reset();
        int wr_cnt = 0;
        int en_cnt = 0;
        int done_cnt = 0;
        clear_inputs();
        for (int c = 0; c < 50; c++) begin
            start = (c == 0) || (c == 3) || (c == 12) || (c == 32) || (c == 35);
            row_valid = 1'b1; set_row(1);
            @(negedge clk);
            if (c <= 34) begin
                if (WrEn) wr_cnt++;
                if (en) en_cnt++;
            end
            if (c == 32) begin
                checks++; if (done !== 1'b1) begin
                    errors++; $display("FAIL ign_done got %b exp 1", done);
                end
            end
            if (c == 33) begin
                checks++; if (busy !== 1'b0 || row_ready !== 1'b0) begin
                    errors++; $display("FAIL ign_start_in_done got %b%b exp 00", busy, row_ready);
                end
            end
            next_cycle();
        end
        checks++; if (wr_cnt != 8 || en_cnt != 23) begin
            errors++; $display("FAIL ign_counts got %0d/%0d exp 8/23", wr_cnt, en_cnt);
        end
        start = 1'b0; row_valid = 1'b0;
        #2;
        checks++; if (en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL areset_pre got %b%b exp 11", en, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (en !== 1'b0 || busy !== 1'b0 || Arow !== 3'd0) begin
            errors++; $display("FAIL areset_immediate got %b%b/%0d exp 00/0", en, busy, Arow);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
            next_cycle();
        end
        checks++; if (done_cnt != 0) begin
            errors++; $display("FAIL areset_no_done got %0d exp 0", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_stall();
        test_abort();
        test_ignored_start_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
